circular_read_ctrl: RTL

Read-side controller for a circular buffer whose write pointer is produced by a wrapping enable-driven counter sharing the same `max`. It tracks occupancy from the writer's per-cycle write pulse and issues reads to a synchronous-read RAM at its own wrapping read pointer. It presents the returned words on a valid/ready output stream at full throughput of one word per cycle. It sits between the buffer RAM and the downstream consumer.

---
 rtl/circular_read_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/circular_read_ctrl.sv
// Read-side controller for a circular buffer: tracks occupancy from the writer's
// pulse, prefetches from a synchronous-read RAM and streams words out via a 2-entry skid FIFO.
module circular_read_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      max,
  input  logic                  wr_en,
  output logic                  rd_en,
  output logic [WIDTH-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH:0]        count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int unsigned CW = WIDTH + 1;

  logic [WIDTH-1:0]      rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] skid_q [2];
  logic                  skid_wp_q;
  logic                  skid_rp_q;
  logic [1:0]            skid_n_q;

  logic [CW-1:0]         depth;
  logic [1:0]            pending;
  logic                  pop;
  logic                  push;
  logic [CW-1:0]         count_d;
  logic                  overflow_d;
  logic [WIDTH-1:0]      rd_ptr_d;
  logic [1:0]            skid_n_d;

  // Occupancy, read issue and skid-FIFO bookkeeping
  always_comb begin
    depth      = CW'(max) + CW'(1);
    full       = (count_q == depth);
    empty      = (count_q == '0);
    out_valid  = (skid_n_q != 2'd0);
    out_data   = skid_q[skid_rp_q];
    pop        = out_valid & out_ready;
    push       = inflight_q;
    pending    = skid_n_q + 2'(inflight_q);
    rd_en      = (count_q != '0) && ((pending - 2'(pop)) < 2'd2);
    rd_addr    = rd_ptr_q;
    count      = count_q;
    overflow   = overflow_q;

    count_d    = count_q;
    overflow_d = overflow_q;
    rd_ptr_d   = rd_ptr_q;
    skid_n_d   = skid_n_q + 2'(push) - 2'(pop);

    unique case ({wr_en, rd_en})
      2'b10: begin
        if (full) overflow_d = 1'b1;
        else      count_d    = count_q + CW'(1);
      end
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (rd_en) rd_ptr_d = (rd_ptr_q == max) ? '0 : rd_ptr_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      inflight_q <= 1'b0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      skid_wp_q  <= 1'b0;
      skid_rp_q  <= 1'b0;
      skid_n_q   <= 2'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      inflight_q <= rd_en;
      skid_n_q   <= skid_n_d;
      // RAM data returns the cycle after the strobe; capture it then
      if (push) begin
        skid_q[skid_wp_q] <= mem_rdata;
        skid_wp_q         <= ~skid_wp_q;
      end
      if (pop) skid_rp_q <= ~skid_rp_q;
    end
  end

endmodule
